vend_session_arbiter: RTL and testbench

- Shares one vending dispenser between two customer panels (panel 0, panel 1).
- Grants one panel at a time, round-robin, and accumulates that panel's coin credit in units of 10 dollars.
- On confirm, issues a one-cycle vend command: item code plus change in 10-dollar units.
- Refunds on cancel or inactivity timeout, then rearbitrates.

---
 rtl/vend_session_arbiter_if.sv | 39 +++
 rtl/vend_session_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vend_session_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/vend_session_arbiter_if.sv
// ---------------------------------------------------------------------------
// vend_session_arbiter_if
// Bundles the customer-panel signals and the dispenser-side results of the
// vending session arbiter.
//   req         [1:0] per-panel service request (level)
//   coin0/coin1 [1:0] panel coin: 2'b01 = 10, 2'b10 = 50, others = none
//   sel         [1:0] per-panel item select (0 = 20-dollar, 1 = 50-dollar)
//   confirm     [1:0] per-panel buy strobe
//   grant       [1:0] one-hot granted panel, 2'b00 when idle
//   coin_reject       one-cycle pulse, coin refused (credit overflow)
//   done              one-cycle pulse ending a session
//   item_valid        with done: 1 = item dispensed, 0 = refund only
//   item              dispensed item code
//   change      [2:0] change or refund in 10-dollar units
// master: panel / stimulus side. slave: the arbiter.
// ---------------------------------------------------------------------------
interface vend_session_arbiter_if;
  logic [1:0] req;
  logic [1:0] coin0;
  logic [1:0] coin1;
  logic [1:0] sel;
  logic [1:0] confirm;
  logic [1:0] grant;
  logic       coin_reject;
  logic       done;
  logic       item_valid;
  logic       item;
  logic [2:0] change;

  modport master (
    output req, coin0, coin1, sel, confirm,
    input  grant, coin_reject, done, item_valid, item, change
  );

  modport slave (
    input  req, coin0, coin1, sel, confirm,
    output grant, coin_reject, done, item_valid, item, change
  );
endinterface

// File: rtl/vend_session_arbiter.sv
// ---------------------------------------------------------------------------
// vend_session_arbiter
// Shares one vending dispenser between two customer panels. One panel is
// granted at a time (round-robin), its coin credit is accumulated in
// 10-dollar units, and the session ends with a one-cycle vend or refund.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    vend_session_arbiter_if.slave (requests, coins, selects,
//          confirms in; grant, coin_reject, done, item_valid, item,
//          change out). All outputs are registered.
// Parameters:
//   TIMEOUT  idle COLLECT cycles without an accepted coin before refund
//   TW       width of the inactivity timer
// ---------------------------------------------------------------------------
module vend_session_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  vend_session_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_VEND,
    ST_REFUND
  } state_t;

  state_t        r_state;
  logic [1:0]    r_grant;
  logic          r_ptr;
  logic [2:0]    r_credit;
  logic [TW-1:0] r_timer;
  logic          r_done;
  logic          r_itemValid;
  logic          r_item;
  logic [2:0]    r_change;
  logic          r_coinReject;

  logic          w_gntIdx;
  logic          w_gReq;
  logic [1:0]    w_gCoin;
  logic          w_gSel;
  logic          w_gConfirm;
  logic [2:0]    w_coinVal;
  logic [3:0]    w_sum;
  logic          w_coinSeen;
  logic          w_coinOk;
  logic          w_coinRej;
  logic [2:0]    w_creditNext;
  logic [2:0]    w_price;
  logic          w_canBuy;
  logic [TW-1:0] w_timerInc;
  logic          w_timeout;
  logic          w_winner;

  // Only the granted panel's inputs are visible during a session.
  assign w_gntIdx   = r_grant[1];
  assign w_gReq     = w_gntIdx ? bus.req[1]     : bus.req[0];
  assign w_gCoin    = w_gntIdx ? bus.coin1      : bus.coin0;
  assign w_gSel     = w_gntIdx ? bus.sel[1]     : bus.sel[0];
  assign w_gConfirm = w_gntIdx ? bus.confirm[1] : bus.confirm[0];

  always_comb begin
    w_coinVal = 3'd0;
    case (w_gCoin)
      2'b01:   w_coinVal = 3'd1;
      2'b10:   w_coinVal = 3'd5;
      default: w_coinVal = 3'd0;
    endcase
  end

  // A coin is refused when the 4-bit sum would not fit the 3-bit credit.
  assign w_sum        = {1'b0, r_credit} + {1'b0, w_coinVal};
  assign w_coinSeen   = (w_coinVal != 3'd0);
  assign w_coinOk     = w_coinSeen && !w_sum[3];
  assign w_coinRej    = w_coinSeen && w_sum[3];
  assign w_creditNext = w_coinOk ? w_sum[2:0] : r_credit;

  // A same-cycle coin counts toward the price.
  assign w_price  = w_gSel ? 3'd5 : 3'd2;
  assign w_canBuy = (w_creditNext >= w_price);

  // The timeout fires on the cycle whose increment would reach TIMEOUT.
  assign w_timerInc = r_timer + TW'(1);
  assign w_timeout  = (w_timerInc == TW'(TIMEOUT));

  // The pointer panel wins only a tie; a lone requester always wins.
  assign w_winner = (bus.req == 2'b11) ? r_ptr : bus.req[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= 2'b00;
      r_ptr        <= 1'b0;
      r_credit     <= 3'd0;
      r_timer      <= '0;
      r_done       <= 1'b0;
      r_itemValid  <= 1'b0;
      r_item       <= 1'b0;
      r_change     <= 3'd0;
      r_coinReject <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_itemValid  <= 1'b0;
      r_item       <= 1'b0;
      r_change     <= 3'd0;
      r_coinReject <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|bus.req) begin
            r_grant  <= w_winner ? 2'b10 : 2'b01;
            r_credit <= 3'd0;
            r_timer  <= '0;
            r_state  <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          r_coinReject <= w_coinRej;
          // Cancel beats confirm, confirm beats timeout.
          if (!w_gReq) begin
            r_done   <= 1'b1;
            r_change <= r_credit;
            r_state  <= ST_REFUND;
          end else if (w_gConfirm && w_canBuy) begin
            r_done      <= 1'b1;
            r_itemValid <= 1'b1;
            r_item      <= w_gSel;
            r_change    <= w_creditNext - w_price;
            r_credit    <= w_creditNext;
            r_state     <= ST_VEND;
          end else if (!w_coinOk && w_timeout) begin
            r_done   <= 1'b1;
            r_change <= r_credit;
            r_state  <= ST_REFUND;
          end else begin
            r_credit <= w_creditNext;
            r_timer  <= w_coinOk ? '0 : w_timerInc;
          end
        end
        ST_VEND, ST_REFUND: begin
          r_grant  <= 2'b00;
          r_ptr    <= ~w_gntIdx;
          r_credit <= 3'd0;
          r_timer  <= '0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_grant <= 2'b00;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.coin_reject = r_coinReject;
  assign bus.done        = r_done;
  assign bus.item_valid  = r_itemValid;
  assign bus.item        = r_item;
  assign bus.change      = r_change;

endmodule

// File: tb/tb_vend_session_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vend_session_arbiter
// Directed bench for vend_session_arbiter (TIMEOUT = 4). Inputs change 1 ns
// after a rising edge; outputs are observed at the same point, so each
// applyStimulus call shows the registered result of the inputs it applied.
// ---------------------------------------------------------------------------
module tb_vend_session_arbiter;

  logic clk;
  logic rst_n;
  int   totalChecks;
  int   badChecks;

  vend_session_arbiter_if vifBus ();

  vend_session_arbiter #(
    .TIMEOUT(4),
    .TW     (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (vifBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of panel inputs, then move to 1 ns past the next edge.
  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] c0,
                               input logic [1:0] c1, input logic [1:0] sel,
                               input logic [1:0] cf);
    vifBus.req     = req;
    vifBus.coin0   = c0;
    vifBus.coin1   = c1;
    vifBus.sel     = sel;
    vifBus.confirm = cf;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    rst_n = 1'b0;
    vifBus.req = 2'b00; vifBus.coin0 = 2'b00; vifBus.coin1 = 2'b00;
    vifBus.sel = 2'b00; vifBus.confirm = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_grant", 32'(vifBus.grant), 0);
    checkOutput("rst_done", 32'(vifBus.done), 0);
    checkOutput("rst_change", 32'(vifBus.change), 0);
    checkOutput("rst_reject", 32'(vifBus.coin_reject), 0);
    rst_n = 1'b1;

    $display("[TB] panel 0: 10+10, buy 20");
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("a_grant", 32'(vifBus.grant), 1);
    applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    checkOutput("a_done", 32'(vifBus.done), 1);
    checkOutput("a_ivalid", 32'(vifBus.item_valid), 1);
    checkOutput("a_item", 32'(vifBus.item), 0);
    checkOutput("a_change", 32'(vifBus.change), 0);
    checkOutput("a_grant_vend", 32'(vifBus.grant), 1);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("a_grant_idle", 32'(vifBus.grant), 0);
    checkOutput("a_done_off", 32'(vifBus.done), 0);

    $display("[TB] panel 1: 50+10 buy 20, then 50 + (10 with buy 50)");
    applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("b_grant", 32'(vifBus.grant), 2);
    applyStimulus(2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
    applyStimulus(2'b10, 2'b00, 2'b01, 2'b00, 2'b00);
    applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 2'b10);
    checkOutput("b_done", 32'(vifBus.done), 1);
    checkOutput("b_change4", 32'(vifBus.change), 4);
    checkOutput("b_ivalid", 32'(vifBus.item_valid), 1);
    applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("b_idle_gap", 32'(vifBus.grant), 0);
    applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("b_regrant", 32'(vifBus.grant), 2);
    applyStimulus(2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
    applyStimulus(2'b10, 2'b00, 2'b01, 2'b10, 2'b10);
    checkOutput("b_change1", 32'(vifBus.change), 1);
    checkOutput("b_item1", 32'(vifBus.item), 1);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    $display("[TB] overflow reject, short confirm, cancel");
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("c_grant", 32'(vifBus.grant), 1);
    applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b01, 2'b10, 2'b00, 2'b00, 2'b00);
    checkOutput("c_reject", 32'(vifBus.coin_reject), 1);
    checkOutput("c_rej_nodone", 32'(vifBus.done), 0);
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
    checkOutput("c_reject_off", 32'(vifBus.coin_reject), 0);
    checkOutput("c_short_buy", 32'(vifBus.done), 0);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("c_refund_done", 32'(vifBus.done), 1);
    checkOutput("c_refund_iv", 32'(vifBus.item_valid), 0);
    checkOutput("c_refund_chg", 32'(vifBus.change), 3);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    $display("[TB] reset mid-session with credit 5");
    applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("r_grant_pre", 32'(vifBus.grant), 2);
    applyStimulus(2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
    rst_n = 1'b0;
    #1;
    checkOutput("r_grant_async", 32'(vifBus.grant), 0);
    checkOutput("r_done_async", 32'(vifBus.done), 0);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("r_no_done", 32'(vifBus.done), 0);

    $display("[TB] both panels requesting continuously");
    applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("d_grant0", 32'(vifBus.grant), 1);
    applyStimulus(2'b11, 2'b01, 2'b10, 2'b00, 2'b00);
    applyStimulus(2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 2'b01);
    checkOutput("d_done0", 32'(vifBus.done), 1);
    checkOutput("d_ignore_p1", 32'(vifBus.change), 0);
    applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("d_idle", 32'(vifBus.grant), 0);
    applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("d_grant1", 32'(vifBus.grant), 2);
    applyStimulus(2'b11, 2'b00, 2'b10, 2'b10, 2'b10);
    checkOutput("d_item1", 32'(vifBus.item), 1);
    checkOutput("d_change1", 32'(vifBus.change), 0);
    applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("d_grant2", 32'(vifBus.grant), 1);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("d_cancel", 32'(vifBus.done), 1);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    $display("[TB] inactivity timeout");
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("e_grant", 32'(vifBus.grant), 1);
    applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("e_pre_timeout", 32'(vifBus.done), 0);
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("e_to_done", 32'(vifBus.done), 1);
    checkOutput("e_to_iv", 32'(vifBus.item_valid), 0);
    checkOutput("e_to_change", 32'(vifBus.change), 1);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    checkOutput("e_coin_saves", 32'(vifBus.done), 0);
    checkOutput("e_still_grant", 32'(vifBus.grant), 1);
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("e_restart", 32'(vifBus.done), 0);
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("e_to2_done", 32'(vifBus.done), 1);
    checkOutput("e_to2_change", 32'(vifBus.change), 2);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
